key_load_ctrl: RTL and testbench
================================

# key_load_ctrl

Sequencing controller for the key-locked FSM benchmarks. It accepts a KEY_W-bit activation key over a serial valid/ready stream and holds the locked FSM in reset while the key is loading. It then commits the key in parallel to the FSM's `keyinput` pins and releases the FSM reset after a programmable settle window. It sits between the test/activation interface and the locked core, one instance per locked core.

## Interface
- `KEY_W`, default 8: key width in bits; legal range 2..64.
- `HOLD_CYC`, default 2: cycles the core reset stays asserted after commit; legal range 1..255.
- `CNT_W`, default 8: width of the commit counter.

- `clk`  in  1: single clock; all state updates on posedge.
- `rst`  in  1: asynchronous, active-low reset.
- `load_start`  in  1: single-cycle request to begin a (re)load.
- `key_valid`  in  1: serial key beat valid.
- `key_bit`  in  1: serial key data; MSB first.
- `key_last`  in  1: marks the final beat; qualified by `key_valid`.
- `key_ready`  out  1: controller accepts a beat this cycle.
- `key_out`  out  KEY_W: committed key, drives the core's key inputs.
- `core_rst`  out  1: active-high reset to the locked core.
- `key_done`  out  1: key committed and core running.
- `err`  out  1: sticky framing error.
- `commit_cnt`  out  CNT_W: number of successful commits, saturating.

## Operation
- States: IDLE, SHIFT, COMMIT, HOLD, RUN.
- Reset values: state IDLE, `key_out`=0, shadow=0, bit_cnt=0, hold_cnt=0, `err`=0, `commit_cnt`=0.
- Outputs decoded from state: `core_rst`=1 and `key_done`=0 in every state except RUN; in RUN, `core_rst`=0 and `key_done`=1.
- `key_ready` = (state==SHIFT) && !`load_start`. This is combinational. A beat is accepted only when `key_valid` && `key_ready`.
- IDLE: on `load_start`, go to SHIFT. Clear shadow and bit_cnt, and clear `err`.
- SHIFT, accepted beat: shadow <= {shadow[KEY_W-2:0], `key_bit`}; bit_cnt increments.
  - `key_last` with bit_cnt==KEY_W-1: go to COMMIT.
  - `key_last` with bit_cnt<KEY_W-1 (short frame): set `err`, discard shadow, go to IDLE.
  - Beat at bit_cnt==KEY_W-1 without `key_last` (long frame): set `err`, discard shadow, go to IDLE.
- SHIFT with `load_start`: restart. Clear shadow and bit_cnt and stay in SHIFT. Any concurrent beat is not accepted.
- COMMIT: `key_out` <= shadow; `commit_cnt` increments, saturating at all-ones. Clear hold_cnt and go to HOLD.
- HOLD: hold_cnt increments each cycle. When hold_cnt==HOLD_CYC-1, go to RUN.
- RUN: on `load_start`, go to SHIFT; `core_rst` reasserts on the next edge. `key_out` keeps the old key until the next COMMIT.
- On a framing error, `key_out` is unchanged and the core stays in reset until a successful load.
- `load_start` in COMMIT or HOLD is ignored.
- Mid-operation `rst` assertion: everything returns to reset values immediately, including `core_rst`=1 and `key_out`=0.

## Timing
- All registered outputs change on posedge only, so they are stable at the core's negedge sampling.
- Let E0 be the edge that accepts the last beat:
  - State is COMMIT after E0.
  - `key_out` shows the new key after E0+1.
  - `core_rst` falls and `key_done` rises after E0+1+HOLD_CYC.
- `load_start` accepted at edge E in IDLE or RUN: `key_ready` is high in the cycle after E.
- Throughput: one beat per cycle, so a full load takes KEY_W cycles minimum.
- `err` sets on the same edge that rejects the frame.

## Structure
- Shared package `key_ctrl_pkg` holds:
  - the state enum;
  - default `KEY_W` and `HOLD_CYC` constants, shared with the locked-core wrappers.
- Sub-module `key_shift_reg` (shadow register plus bit counter with clear/shift/full) is natural. The FSM, hold counter and commit counter stay in the top.

## Test plan
- Load 8'hA5 at full rate with `key_last` on beat 8 -> `key_out`=8'hA5 one edge after the last beat; `core_rst` falls 3 edges after it (HOLD_CYC=2); `commit_cnt`=1.
- `key_last` on beat 5 -> `err`=1, state IDLE, `key_out` unchanged, `core_rst` stays 1. Then a good load of 8'h3C -> `err` clears at `load_start`, `key_out`=8'h3C.
- 8 beats without `key_last` -> `err`=1 on the 8th beat edge.
- In RUN with key 8'hA5, issue `load_start` -> `core_rst`=1 on the next edge, `key_out` stays 8'hA5 until 8'h5A commits.
- `load_start` together with `key_valid` on beat 4 -> `key_ready`=0 that cycle, count restarts, 8 further beats are required.
- Assert `rst` in HOLD -> `key_out`=0, `core_rst`=1, `commit_cnt`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/key_ctrl_pkg.sv
// Shared definitions for the key-load sequencing controller and the locked-core wrappers.
package key_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_COMMIT = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RUN    = 3'd4
    } key_state_e;

    localparam int KEY_W_DEF    = 8;
    localparam int HOLD_CYC_DEF = 2;

endpackage

// File: rtl/key_shift_reg.sv
// Shadow register for the serial key (MSB first) plus its beat counter.
module key_shift_reg #(
    parameter int KEY_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift,
    input  logic             bit_in,
    output logic [KEY_W-1:0] shadow,
    output logic             full
);

    localparam int CW = $clog2(KEY_W);

    logic [KEY_W-1:0] shadow_r;
    logic [CW-1:0]    bit_cnt_r;

    // Clear wins over shift so a rejected or restarted frame leaves nothing behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_r  <= {KEY_W{1'b0}};
            bit_cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            shadow_r  <= {KEY_W{1'b0}};
            bit_cnt_r <= {CW{1'b0}};
        end else if (shift) begin
            shadow_r  <= {shadow_r[KEY_W-2:0], bit_in};
            bit_cnt_r <= bit_cnt_r + CW'(1);
        end
    end

    assign shadow = shadow_r;
    assign full   = (bit_cnt_r == CW'(KEY_W - 1));

endmodule

// File: rtl/key_load_ctrl.sv
// Loads a serial activation key, commits it to the locked core and sequences the core reset.
module key_load_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int KEY_W    = KEY_W_DEF,
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             key_valid,
    input  logic             key_bit,
    input  logic             key_last,
    output logic             key_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             core_rst,
    output logic             key_done,
    output logic             err,
    output logic [CNT_W-1:0] commit_cnt
);

    key_state_e       state_r;
    logic [KEY_W-1:0] key_out_r;
    logic [7:0]       hold_cnt_r;
    logic             err_r;
    logic [CNT_W-1:0] commit_cnt_r;
    logic             core_rst_r;
    logic             key_done_r;

    logic [KEY_W-1:0] shadow_s;
    logic             full_s;
    logic             accept_s;
    logic             frame_err_s;
    logic             clr_s;

    assign key_ready = (state_r == ST_SHIFT) && !load_start;

    // Beat acceptance, framing check and shadow clear requests.
    always_comb begin
        accept_s    = key_valid && key_ready;
        frame_err_s = 1'b0;
        if (accept_s) begin
            frame_err_s = key_last ? !full_s : full_s;
        end else begin
            frame_err_s = 1'b0;
        end
        clr_s = frame_err_s
             || (load_start && ((state_r == ST_IDLE) || (state_r == ST_SHIFT) || (state_r == ST_RUN)));
    end

    key_shift_reg #(
        .KEY_W (KEY_W)
    ) u_shift (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_s),
        .shift  (accept_s),
        .bit_in (key_bit),
        .shadow (shadow_s),
        .full   (full_s)
    );

    // Sequencing FSM; core_rst/key_done are registered alongside the state that implies them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            key_out_r    <= {KEY_W{1'b0}};
            hold_cnt_r   <= 8'd0;
            err_r        <= 1'b0;
            commit_cnt_r <= {CNT_W{1'b0}};
            core_rst_r   <= 1'b1;
            key_done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_start) begin
                        state_r <= ST_SHIFT;
                        err_r   <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (frame_err_s) begin
                        state_r <= ST_IDLE;
                        err_r   <= 1'b1;
                    end else if (accept_s && key_last) begin
                        state_r <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    key_out_r  <= shadow_s;
                    hold_cnt_r <= 8'd0;
                    state_r    <= ST_HOLD;
                    if (commit_cnt_r != {CNT_W{1'b1}}) begin
                        commit_cnt_r <= commit_cnt_r + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    hold_cnt_r <= hold_cnt_r + 8'd1;
                    if (hold_cnt_r == 8'(HOLD_CYC - 1)) begin
                        state_r    <= ST_RUN;
                        core_rst_r <= 1'b0;
                        key_done_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (load_start) begin
                        state_r    <= ST_SHIFT;
                        err_r      <= 1'b0;
                        core_rst_r <= 1'b1;
                        key_done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    core_rst_r <= 1'b1;
                    key_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign key_out    = key_out_r;
    assign core_rst   = core_rst_r;
    assign key_done   = key_done_r;
    assign err        = err_r;
    assign commit_cnt = commit_cnt_r;

endmodule

// File: tb/tb_key_load_ctrl.sv
// Randomized self-checking bench for key_load_ctrl against a frame-level reference model.
module tb_key_load_ctrl;

    localparam int KW = 8;
    localparam int HC = 2;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic          key_valid;
    logic          key_bit;
    logic          key_last;
    logic          key_ready;
    logic [KW-1:0] key_out;
    logic          core_rst;
    logic          key_done;
    logic          err;
    logic [CW-1:0] commit_cnt;

    int            vectors = 0;
    int            miscompares = 0;
    logic [KW-1:0] exp_key;
    int            commits;
    bit            gaps;

    key_load_ctrl #(.KEY_W(KW), .HOLD_CYC(HC), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .key_valid  (key_valid),
        .key_bit    (key_bit),
        .key_last   (key_last),
        .key_ready  (key_ready),
        .key_out    (key_out),
        .core_rst   (core_rst),
        .key_done   (key_done),
        .err        (err),
        .commit_cnt (commit_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] exp_cnt();
        int sat;
        sat = (1 << CW) - 1;
        return CW'((commits > sat) ? sat : commits);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic b, input logic last);
        if (gaps && ($urandom_range(0, 3) == 0)) begin
            key_valid = 1'b0;
            key_last  = 1'b1;
            key_bit   = 1'($urandom);
            step();
        end
        key_valid = 1'b1;
        key_bit   = b;
        key_last  = last;
        step();
        key_valid = 1'b0;
        key_last  = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        #1;
        vectors++;
        if (core_rst !== 1'b1 || key_done !== 1'b0 || key_ready !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL start: core_rst=%b key_done=%b key_ready=%b err=%b, expected 1 0 1 0",
                     core_rst, key_done, key_ready, err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; load_start = 1'b0; key_valid = 1'b0; key_bit = 1'b0; key_last = 1'b0;
        exp_key = '0; commits = 0; gaps = 1'b0;
        #12;
        vectors++;
        if (key_out !== '0 || core_rst !== 1'b1 || key_done !== 1'b0 || err !== 1'b0
            || commit_cnt !== '0 || key_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: key_out=%h core_rst=%b key_done=%b err=%b cnt=%0d ready=%b",
                     key_out, core_rst, key_done, err, commit_cnt, key_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    // A complete frame; checks latency of key_out and core reset release.
    task automatic test_good_load(input logic [KW-1:0] k, input bit do_start);
        if (do_start) start_load();
        for (int i = KW - 1; i >= 0; i--) beat(k[i], (i == 0));
        vectors++;
        if (key_out !== exp_key || core_rst !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_commit: key_out=%h core_rst=%b err=%b, expected %h 1 0",
                     key_out, core_rst, err, exp_key);
        end
        step();
        exp_key = k;
        commits++;
        vectors++;
        if (key_out !== exp_key || commit_cnt !== exp_cnt() || core_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL commit: key_out=%h cnt=%0d core_rst=%b, expected %h %0d 1",
                     key_out, commit_cnt, core_rst, exp_key, exp_cnt());
        end
        for (int c = 1; c < HC; c++) step();
        vectors++;
        if (core_rst !== 1'b1 || key_done !== 1'b0) begin
            miscompares++;
            $display("FAIL hold: core_rst=%b key_done=%b, expected 1 0", core_rst, key_done);
        end
        step();
        vectors++;
        if (core_rst !== 1'b0 || key_done !== 1'b1 || key_out !== exp_key) begin
            miscompares++;
            $display("FAIL run: core_rst=%b key_done=%b key_out=%h, expected 0 1 %h",
                     core_rst, key_done, key_out, exp_key);
        end
    endtask

    // Short frame (with_last, n<KW) or long frame (no key_last, n==KW).
    task automatic test_bad_frame(input int n, input bit with_last);
        start_load();
        for (int i = 1; i <= n; i++) begin
            if (i == n && !with_last) begin
                vectors++;
                if (err !== 1'b0 || key_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL long_pre: err=%b ready=%b, expected 0 1", err, key_ready);
                end
            end
            beat(1'($urandom), with_last && (i == n));
        end
        vectors++;
        if (err !== 1'b1 || key_ready !== 1'b0 || key_out !== exp_key
            || core_rst !== 1'b1 || key_done !== 1'b0 || commit_cnt !== exp_cnt()) begin
            miscompares++;
            $display("FAIL frame_err n=%0d: err=%b ready=%b key_out=%h core_rst=%b cnt=%0d, expected 1 0 %h 1 %0d",
                     n, err, key_ready, key_out, core_rst, commit_cnt, exp_key, exp_cnt());
        end
        step();
        vectors++;
        if (err !== 1'b1 || core_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: err=%b core_rst=%b, expected 1 1", err, core_rst);
        end
    endtask

    // load_start colliding with a beat restarts the frame; a full frame must follow.
    task automatic test_restart(input int pos, input logic [KW-1:0] k);
        start_load();
        for (int i = 0; i < pos; i++) beat(1'($urandom), 1'b0);
        load_start = 1'b1;
        key_valid  = 1'b1;
        key_bit    = 1'($urandom);
        key_last   = 1'b0;
        #1;
        vectors++;
        if (key_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_ready: key_ready=%b, expected 0", key_ready);
        end
        step();
        load_start = 1'b0;
        key_valid  = 1'b0;
        test_good_load(k, 1'b0);
    endtask

    task automatic test_async_reset();
        logic [KW-1:0] k;
        k = KW'($urandom);
        start_load();
        for (int i = KW - 1; i >= 0; i--) beat(k[i], (i == 0));
        step();
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (key_out !== '0 || core_rst !== 1'b1 || commit_cnt !== '0 || key_done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL async_rst: key_out=%h core_rst=%b cnt=%0d key_done=%b err=%b, expected 0 1 0 0 0",
                     key_out, core_rst, commit_cnt, key_done, err);
        end
        exp_key = '0;
        commits = 0;
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_random();
        gaps = 1'b1;
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: test_good_load(KW'($urandom), 1'b1);
                3:       test_bad_frame($urandom_range(1, KW - 1), 1'b1);
                4:       test_bad_frame(KW, 1'b0);
                default: test_restart($urandom_range(0, KW - 2), KW'($urandom));
            endcase
        end
        gaps = 1'b0;
    endtask

    initial begin
        test_reset();
        test_good_load(8'hA5, 1'b1);
        test_bad_frame(5, 1'b1);
        test_good_load(8'h3C, 1'b1);
        test_bad_frame(KW, 1'b0);
        test_good_load(8'hA5, 1'b1);
        test_good_load(8'h5A, 1'b1);
        test_restart(4, 8'hC3);
        test_async_reset();
        test_random();
        for (int i = 0; i < 9; i++) test_good_load(KW'($urandom), 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
